// File: rtl/serial_port_router.sv
// Serial frame receiver: start bit, port, length, payload.
// Payload bits are steered to one of 2**PORT_W output ports.
module serial_port_router #(
    parameter int PORT_W = 2,
    parameter int LEN_W  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clk_en,
    input  logic                   ser_in,
    output logic [2**PORT_W-1:0]   port_data,
    output logic [2**PORT_W-1:0]   port_valid,
    output logic [LEN_W-1:0]       remaining,
    output logic                   busy,
    output logic                   done
);

    localparam int NPORTS  = 2**PORT_W;
    localparam int CNT_MAX = (PORT_W > LEN_W) ? PORT_W : LEN_W;
    localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] PORT = 3'd1;
    localparam logic [2:0] LEN  = 3'd2;
    localparam logic [2:0] DATA = 3'd3;
    localparam logic [2:0] DONE = 3'd4;

    logic [2:0]        state;
    logic [PORT_W-1:0] port_sr;
    logic [LEN_W-1:0]  len_sr;
    logic [CNT_W-1:0]  cnt;
    logic [PORT_W-1:0] port_nxt;
    logic [LEN_W-1:0]  len_nxt;
    logic              port_last;
    logic              len_last;

    assign port_nxt  = (port_sr << 1) | PORT_W'(ser_in);
    assign len_nxt   = (len_sr << 1) | LEN_W'(ser_in);
    assign port_last = (cnt == CNT_W'(PORT_W - 1));
    assign len_last  = (cnt == CNT_W'(LEN_W - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            port_sr   <= '0;
            len_sr    <= '0;
            cnt       <= '0;
            remaining <= '0;
        end else if (clk_en) begin
            unique case (state)
                IDLE: begin
                    if (!ser_in) begin
                        state   <= PORT;
                        cnt     <= '0;
                        port_sr <= '0;
                        len_sr  <= '0;
                    end
                end
                PORT: begin
                    port_sr <= port_nxt;
                    if (port_last) begin
                        state <= LEN;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                LEN: begin
                    len_sr <= len_nxt;
                    if (len_last) begin
                        // Length lands in remaining on its own last bit.
                        remaining <= len_nxt;
                        cnt       <= '0;
                        state     <= (len_nxt == '0) ? DONE : DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (remaining != '0)
                        remaining <= remaining - 1'b1;
                    if (remaining <= LEN_W'(1))
                        state <= DONE;
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        port_data  = '0;
        port_valid = '0;
        if (state == DATA && clk_en) begin
            port_data[port_sr]  = ser_in;
            port_valid[port_sr] = 1'b1;
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    logic unused_np;
    assign unused_np = (NPORTS == 0);

endmodule

// File: doc/serial_port_router.md
Name: serial_port_router

Overview:
- Parametrised serial frame receiver and demultiplexer; generalises the fixed 4-port / 4-bit-length serial-to-port datapath.
- Includes its own control FSM.
- Decodes a frame on one serial line: start bit, destination port number, payload length, payload bits. Routes each payload bit to the selected output port.
- Exposes a remaining-bit count for the 7-segment display path.

Parameters:
- PORT_W, 2, width of the port-number field; number of ports NPORTS = 2**PORT_W (derived localparam).
- LEN_W, 4, width of the payload-length field; maximum payload is 2**LEN_W-1 bits.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- clk_en  in  1  bit-rate enable; all state advances only on clk edges with clk_en=1.
- ser_in  in  1  serial input, MSB-first fields.
- port_data  out  NPORTS  routed payload bit; bit i is the output for port i.
- port_valid  out  NPORTS  qualifies port_data per port.
- remaining  out  LEN_W  payload bits still to be routed (registered).
- busy  out  1  high when a frame is in progress (state != IDLE).
- done  out  1  one-enabled-cycle frame-complete flag.

Behaviour:
- Reset (rst=0, async): state=IDLE; port register, length register, bit counter and remaining are 0; done=0; port_data=0; port_valid=0. Reset is honoured at any point, including mid-frame.
- clk_en=0: every register holds; port_valid forced to 0; no bit is consumed.
- FSM states: IDLE, PORT, LEN, DATA, DONE. Transitions are evaluated only on enabled edges.
- IDLE: ser_in=1 stays IDLE. ser_in=0 (start bit) goes to PORT and clears the bit counter.
- PORT: shift ser_in into the port register, MSB first. After PORT_W sampled bits, go to LEN and clear the bit counter.
- LEN: shift ser_in into the length register, MSB first. On the LEN_W-th bit:
  - Load remaining with the full length including the current ser_in bit, i.e. {len_sr[LEN_W-2:0], ser_in}. No extra cycle is spent.
  - Length=0: go to DONE.
  - Otherwise: go to DATA.
- DATA, each enabled cycle:
  - port_data[port]=ser_in; port_valid[port]=1.
  - All other port bits are 0 / valid 0.
  - remaining decrements by 1.
  - When remaining goes 1->0, go to DONE.
  - port_data and port_valid are combinational from the state, port register, ser_in and clk_en; there is no added latency.
- DONE: done=1 for exactly one enabled cycle (done is held while clk_en=0), then IDLE. ser_in is ignored in DONE; a start bit is recognised from the next enabled cycle in IDLE.
- Outside DATA: port_data=0, port_valid=0.
- remaining width rules: unsigned LEN_W bits; never wraps below 0; holds its last value (0) in DONE/IDLE.
- Frame timing in enabled cycles, start bit at cycle k:
  - port bits at k+1..k+PORT_W;
  - length bits at the next LEN_W cycles;
  - payload over the next L cycles;
  - DONE at the following cycle.
  - Total: 1+PORT_W+LEN_W+L+1 enabled cycles.
- No timeout: a stalled line (clk_en never reasserted) holds the current state indefinitely.

Test Plan:
- PORT_W=2, LEN_W=4, clk_en=1. Send start 0, port 10, length 0011, payload 1,0,1 -> port_valid=4'b0100 for 3 cycles; port_data[2]=1,0,1; remaining 3,2,1,0; done high 1 cycle; busy low afterwards.
- Length 0000 to port 01 -> port_valid never asserts; done high in the cycle after the last length bit; remaining=0.
- Repeat the first case with clk_en pattern 1,0,0,1,... -> identical bit sequence on port 2. All outputs and remaining hold on disabled cycles; port_valid=0 while clk_en=0.
- Assert rst low mid-DATA of a length-9 frame to port 3 -> immediately busy=0, port_valid=0, remaining=0. A following frame to port 0 with length 2 routes correctly.
- ser_in held 1 for 20 cycles -> stays IDLE. Two back-to-back frames with the start bit one cycle after DONE -> both frames routed; the second's start bit is recognised.
- PORT_W=3, LEN_W=5: port 111, length 10001 -> port_valid[7] for exactly 17 cycles; all other 7 ports silent; done once.
